// File: rtl/lc4_div_pkg.sv
// Shared types and widths for the LC4 shared-divider scheduler.
package lc4_div_pkg;

    localparam int XLEN  = 16;
    localparam int TAG_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } div_owner_e;

endpackage

// File: rtl/lc4_div_scheduler_if.sv
// Request/grant/result bundle between the two issue pipes and the shared divider.
interface lc4_div_scheduler_if;
    import lc4_div_pkg::*;

    logic             gwe;
    logic             i_flush;
    logic             i_req_a;
    logic             i_req_b;
    logic [XLEN-1:0]  i_dividend_a;
    logic [XLEN-1:0]  i_dividend_b;
    logic [XLEN-1:0]  i_divisor_a;
    logic [XLEN-1:0]  i_divisor_b;
    logic [TAG_W-1:0] i_tag_a;
    logic [TAG_W-1:0] i_tag_b;
    logic             o_gnt_a;
    logic             o_gnt_b;
    logic             o_busy;
    logic             o_done;
    logic [XLEN-1:0]  o_quotient;
    logic [XLEN-1:0]  o_remainder;
    logic [TAG_W-1:0] o_tag;
    logic             o_owner;

    modport master (
        output gwe, i_flush, i_req_a, i_req_b,
        output i_dividend_a, i_dividend_b, i_divisor_a, i_divisor_b, i_tag_a, i_tag_b,
        input  o_gnt_a, o_gnt_b, o_busy, o_done, o_quotient, o_remainder, o_tag, o_owner
    );

    modport slave (
        input  gwe, i_flush, i_req_a, i_req_b,
        input  i_dividend_a, i_dividend_b, i_divisor_a, i_divisor_b, i_tag_a, i_tag_b,
        output o_gnt_a, o_gnt_b, o_busy, o_done, o_quotient, o_remainder, o_tag, o_owner
    );

endinterface

// File: rtl/lc4_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
module lc4_div_step
    import lc4_div_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] dvd_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] dvd_o,
    output logic            q_bit_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    // One extra bit so divisors with the MSB set still compare correctly.
    assign shifted = {rem_i, dvd_i[XLEN-1]};
    assign diff    = shifted[XLEN-1:0] - divisor_i;
    assign q_bit_o = (shifted >= {1'b0, divisor_i});
    assign rem_o   = q_bit_o ? diff : shifted[XLEN-1:0];
    assign dvd_o   = {dvd_i[XLEN-2:0], 1'b0};

endmodule

// File: rtl/lc4_div_scheduler.sv
// Shares one iterative restoring divider between LC4 issue pipes A and B (A has priority).
// Define LC4_DIV_EARLY_OUT_EN to complete zero-divisor / dividend<divisor operations without RUN.
module lc4_div_scheduler
    import lc4_div_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    lc4_div_scheduler_if.slave div
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvd_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  quo_q;
    logic [TAG_W-1:0] op_tag_q;
    div_owner_e       op_owner_q;
    logic             busy_q;
    logic [XLEN-1:0]  quotient_q;
    logic [XLEN-1:0]  remainder_q;
    logic [TAG_W-1:0] tag_q;
    div_owner_e       owner_q;

    logic             can_accept;
    logic             gnt_a;
    logic             gnt_b;
    logic             accept;
    logic [XLEN-1:0]  in_dvd;
    logic [XLEN-1:0]  in_dvs;
    logic [TAG_W-1:0] in_tag;

    assign can_accept = ((state_q == IDLE) || (state_q == DONE)) && div.gwe && !div.i_flush;
    assign gnt_a      = can_accept && div.i_req_a;
    assign gnt_b      = can_accept && div.i_req_b && !div.i_req_a;
    assign accept     = gnt_a || gnt_b;

    assign in_dvd = gnt_b ? div.i_dividend_b : div.i_dividend_a;
    assign in_dvs = gnt_b ? div.i_divisor_b  : div.i_divisor_a;
    assign in_tag = gnt_b ? div.i_tag_b      : div.i_tag_a;

    logic [XLEN-1:0]           rem_chain [BITS_PER_CYCLE+1];
    logic [XLEN-1:0]           dvd_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bits;
    logic [XLEN-1:0]           quo_d;
    logic                      dvs_zero;

    assign rem_chain[0] = rem_q;
    assign dvd_chain[0] = dvd_q;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            lc4_div_step u_step (
                .rem_i     (rem_chain[gi]),
                .dvd_i     (dvd_chain[gi]),
                .divisor_i (dvs_q),
                .rem_o     (rem_chain[gi+1]),
                .dvd_o     (dvd_chain[gi+1]),
                .q_bit_o   (q_bits[BITS_PER_CYCLE-1-gi])
            );
        end
    endgenerate

    assign quo_d    = {quo_q[XLEN-BITS_PER_CYCLE-1:0], q_bits};
    assign dvs_zero = (dvs_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            op_tag_q    <= '0;
            op_owner_q  <= OWNER_A;
            busy_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            tag_q       <= '0;
            owner_q     <= OWNER_A;
        end else if (div.gwe) begin
            if (accept) begin
                state_q    <= RUN;
                busy_q     <= 1'b1;
                cnt_q      <= CNT_W'(N);
                rem_q      <= '0;
                quo_q      <= '0;
                dvd_q      <= in_dvd;
                dvs_q      <= in_dvs;
                op_tag_q   <= in_tag;
                op_owner_q <= gnt_b ? OWNER_B : OWNER_A;
`ifdef LC4_DIV_EARLY_OUT_EN
                // Result is known at accept time: skip the iterations entirely.
                if ((in_dvs == '0) || (in_dvd < in_dvs)) begin
                    state_q     <= DONE;
                    busy_q      <= 1'b0;
                    quotient_q  <= '0;
                    remainder_q <= (in_dvs == '0) ? '0 : in_dvd;
                    tag_q       <= in_tag;
                    owner_q     <= gnt_b ? OWNER_B : OWNER_A;
                end
`endif
            end else begin
                case (state_q)
                    RUN: begin
                        if (div.i_flush) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            rem_q <= rem_chain[BITS_PER_CYCLE];
                            dvd_q <= dvd_chain[BITS_PER_CYCLE];
                            quo_q <= quo_d;
                            if (cnt_q == CNT_W'(1)) begin
                                state_q     <= DONE;
                                busy_q      <= 1'b0;
                                // A zero divisor yields all-ones from the datapath; LC4 defines 0/0.
                                quotient_q  <= dvs_zero ? '0 : quo_d;
                                remainder_q <= dvs_zero ? '0 : rem_chain[BITS_PER_CYCLE];
                                tag_q       <= op_tag_q;
                                owner_q     <= op_owner_q;
                            end else begin
                                cnt_q <= cnt_q - CNT_W'(1);
                            end
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign div.o_gnt_a     = gnt_a;
    assign div.o_gnt_b     = gnt_b;
    assign div.o_busy      = busy_q;
    assign div.o_done      = (state_q == DONE) && !div.i_flush && div.gwe;
    assign div.o_quotient  = quotient_q;
    assign div.o_remainder = remainder_q;
    assign div.o_tag       = tag_q;
    assign div.o_owner     = owner_q;

endmodule

// File: tb/tb_lc4_div_scheduler.sv
// Self-checking bench for lc4_div_scheduler: vector table, corner sequences, randomized ops vs. arithmetic model.
module tb_lc4_div_scheduler;
    import lc4_div_pkg::*;

    localparam int BPC = 1;
    localparam int N   = XLEN / BPC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lc4_div_scheduler_if bus();

    lc4_div_scheduler #(.BITS_PER_CYCLE(BPC)) dut (
        .clk (clk),
        .rst (rst),
        .div (bus.slave)
    );

    int total  = 0;
    int passed = 0;

    typedef struct {
        bit          pipe;
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [2:0]  tag;
        logic [15:0] q;
        logic [15:0] r;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) ? 16'd0 : a / b;
    endfunction

    function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) ? 16'd0 : a % b;
    endfunction

    function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef LC4_DIV_EARLY_OUT_EN
        if (b == 16'd0 || a < b) return 1;
`endif
        return N + 1;
    endfunction

    // Waits (bounded) for o_done after an accept edge and checks the completion.
    task automatic wait_done(input int exp_lat, input logic [15:0] eq, input logic [15:0] er,
                             input logic [2:0] etag, input logic eown, input string nm);
        int cyc = 0;
        bit seen = 1'b0;
        while (cyc < 100 && !seen) begin
            @(negedge clk);
            cyc++;
            seen = bus.o_done;
        end
        check({nm, " done_seen"}, 32'(seen), 32'd1);
        check({nm, " latency"}, 32'(cyc), 32'(exp_lat));
        check({nm, " quotient"}, 32'(bus.o_quotient), 32'(eq));
        check({nm, " remainder"}, 32'(bus.o_remainder), 32'(er));
        check({nm, " tag"}, 32'(bus.o_tag), 32'(etag));
        check({nm, " owner"}, 32'(bus.o_owner), 32'(eown));
        $display("op %s: q=0x%04h r=0x%04h tag=%0d owner=%0d lat=%0d", nm,
                 bus.o_quotient, bus.o_remainder, bus.o_tag, bus.o_owner, cyc);
    endtask

    task automatic run_op(input bit pipe, input logic [15:0] dvd, input logic [15:0] dvs,
                          input logic [2:0] tag, input logic [15:0] eq, input logic [15:0] er,
                          input string nm);
        @(negedge clk);
        if (pipe) begin
            bus.i_req_b = 1'b1; bus.i_dividend_b = dvd; bus.i_divisor_b = dvs; bus.i_tag_b = tag;
        end else begin
            bus.i_req_a = 1'b1; bus.i_dividend_a = dvd; bus.i_divisor_a = dvs; bus.i_tag_a = tag;
        end
        #1;
        check({nm, " gnt_a"}, 32'(bus.o_gnt_a), 32'(!pipe));
        check({nm, " gnt_b"}, 32'(bus.o_gnt_b), 32'(pipe));
        @(posedge clk);
        #1;
        bus.i_req_a = 1'b0;
        bus.i_req_b = 1'b0;
        wait_done(ref_lat(dvd, dvs), eq, er, tag, pipe, nm);
        @(negedge clk);
        check({nm, " done_pulse"}, 32'(bus.o_done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at;
        int done_cnt;
        logic [15:0] cap_q, cap_r;
        logic [2:0]  cap_tag;
        logic        cap_own;

        vecs[0] = '{1'b0, 16'd100,   16'd7,      3'd3, 16'd14,     16'd2};
        vecs[1] = '{1'b1, 16'd1234,  16'd0,      3'd5, 16'd0,      16'd0};
        vecs[2] = '{1'b0, 16'h8000,  16'd3,      3'd2, 16'h2AAA,   16'd2};
        vecs[3] = '{1'b1, 16'hFFFF,  16'hFFFF,   3'd7, 16'd1,      16'd0};
        vecs[4] = '{1'b0, 16'd5,     16'd9,      3'd1, 16'd0,      16'd5};
        vecs[5] = '{1'b1, 16'hFFFE,  16'hFFFF,   3'd6, 16'd0,      16'hFFFE};
        vecs[6] = '{1'b0, 16'hFFFF,  16'h8001,   3'd4, 16'd1,      16'h7FFE};
        vecs[7] = '{1'b1, 16'd0,     16'd13,     3'd0, 16'd0,      16'd0};

        rst = 1'b1;
        bus.gwe = 1'b1; bus.i_flush = 1'b0;
        bus.i_req_a = 1'b0; bus.i_req_b = 1'b0;
        bus.i_dividend_a = '0; bus.i_dividend_b = '0;
        bus.i_divisor_a = '0; bus.i_divisor_b = '0;
        bus.i_tag_a = '0; bus.i_tag_b = '0;
        #12;
        check("reset busy", 32'(bus.o_busy), 32'd0);
        check("reset done", 32'(bus.o_done), 32'd0);
        check("reset quotient", 32'(bus.o_quotient), 32'd0);
        check("reset remainder", 32'(bus.o_remainder), 32'd0);
        check("reset tag", 32'(bus.o_tag), 32'd0);
        check("reset owner", 32'(bus.o_owner), 32'd0);
        #4 rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].pipe, vecs[i].dvd, vecs[i].dvs, vecs[i].tag, vecs[i].q, vecs[i].r,
                   $sformatf("vec%0d", i));

        // gwe low blocks grants in IDLE
        @(negedge clk);
        bus.gwe = 1'b0; bus.i_req_a = 1'b1; bus.i_dividend_a = 16'd9; bus.i_divisor_a = 16'd2;
        #1;
        check("gwe_low gnt_a", 32'(bus.o_gnt_a), 32'd0);
        @(negedge clk);
        bus.i_req_a = 1'b0; bus.gwe = 1'b1;

        // Simultaneous A and B requests: A first, B accepted in A's DONE cycle
        @(negedge clk);
        bus.i_req_a = 1'b1; bus.i_dividend_a = 16'hFFFF; bus.i_divisor_a = 16'd1; bus.i_tag_a = 3'd1;
        bus.i_req_b = 1'b1; bus.i_dividend_b = 16'd50;   bus.i_divisor_b = 16'd5; bus.i_tag_b = 3'd4;
        #1;
        check("ab gnt_a", 32'(bus.o_gnt_a), 32'd1);
        check("ab gnt_b", 32'(bus.o_gnt_b), 32'd0);
        @(posedge clk);
        #1 bus.i_req_a = 1'b0;
        done_at = -1;
        cap_q = '0; cap_r = '0; cap_tag = '0; cap_own = 1'b0;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (c == 5) check("ab gnt_b_during_run", 32'(bus.o_gnt_b), 32'd0);
            if (bus.o_done) begin
                done_at = c;
                cap_q = bus.o_quotient; cap_r = bus.o_remainder;
                cap_tag = bus.o_tag; cap_own = bus.o_owner;
                check("ab gnt_b_in_done", 32'(bus.o_gnt_b), 32'd1);
            end
        end
        check("ab a latency", 32'(done_at), 32'(N + 1));
        check("ab a quotient", 32'(cap_q), 32'hFFFF);
        check("ab a remainder", 32'(cap_r), 32'd0);
        check("ab a tag", 32'(cap_tag), 32'd1);
        check("ab a owner", 32'(cap_own), 32'd0);
        $display("op ab_a: q=0x%04h r=0x%04h tag=%0d owner=%0d lat=%0d", cap_q, cap_r, cap_tag, cap_own, done_at);
        @(posedge clk);
        #1 bus.i_req_b = 1'b0;
        wait_done(N + 1, 16'd10, 16'd0, 3'd4, 1'b1, "ab_b");

        // Flush at the fifth RUN cycle
        @(negedge clk);
        bus.i_req_a = 1'b1; bus.i_dividend_a = 16'd1000; bus.i_divisor_a = 16'd3; bus.i_tag_a = 3'd5;
        @(posedge clk);
        #1 bus.i_req_a = 1'b0;
        repeat (5) @(negedge clk);
        bus.i_flush = 1'b1;
        #1;
        check("flush busy_before", 32'(bus.o_busy), 32'd1);
        check("flush done", 32'(bus.o_done), 32'd0);
        @(posedge clk);
        #1 bus.i_flush = 1'b0;
        check("flush busy_after", 32'(bus.o_busy), 32'd0);
        run_op(1'b0, 16'd77, 16'd7, 3'd1, 16'd11, 16'd0, "post_flush");

        // Asynchronous reset mid-RUN
        @(negedge clk);
        bus.i_req_b = 1'b1; bus.i_dividend_b = 16'd500; bus.i_divisor_b = 16'd7; bus.i_tag_b = 3'd6;
        @(posedge clk);
        #1 bus.i_req_b = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst busy", 32'(bus.o_busy), 32'd0);
        check("arst done", 32'(bus.o_done), 32'd0);
        check("arst quotient", 32'(bus.o_quotient), 32'd0);
        check("arst remainder", 32'(bus.o_remainder), 32'd0);
        check("arst tag", 32'(bus.o_tag), 32'd0);
        check("arst owner", 32'(bus.o_owner), 32'd0);
        #3 rst = 1'b0;
        done_cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.o_done) done_cnt++;
        end
        check("arst stale_done", 32'(done_cnt), 32'd0);

        // gwe low for four edges during RUN
        @(negedge clk);
        bus.i_req_a = 1'b1; bus.i_dividend_a = 16'h8000; bus.i_divisor_a = 16'd3; bus.i_tag_a = 3'd2;
        @(posedge clk);
        #1 bus.i_req_a = 1'b0;
        done_at = -1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (bus.o_done) done_at = c;
            if (c == 3) bus.gwe = 1'b0;
            if (c == 7) bus.gwe = 1'b1;
        end
        check("gwe latency", 32'(done_at), 32'(N + 1 + 4));
        check("gwe quotient", 32'(bus.o_quotient), 32'h2AAA);
        check("gwe remainder", 32'(bus.o_remainder), 32'd2);
        $display("op gwe_stall: q=0x%04h r=0x%04h lat=%0d", bus.o_quotient, bus.o_remainder, done_at);

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            bit          p;
            logic [15:0] a, b;
            logic [2:0]  t;
            p = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            t = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 15));
                2:       b = 16'($urandom);
                default: b = a + 16'($urandom_range(0, 3));
            endcase
            run_op(p, a, b, t, ref_q(a, b), ref_r(a, b), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
